mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the pipeline's instruction-fetch stage and its MEM-stage data access.
- Sequences each access as issue → wait for memory ack → respond.
- Data accesses have priority, with a bounded starvation guard for fetch.
- Produces a pipeline-wide stall and a sticky timeout error. Sits between the PC/IF-ID front end, the EX-MEM/MEM-WB data path, and the external memory.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_timer.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types for the unified-memory port arbiter: arbiter
//               state encoding, access owner encoding and the default word
//               returned to a requester when the memory never answers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_timer
// Description : Loadable up-counter with synchronous clear and enable and a
//               terminal-count flag. The counter holds at TC_VAL instead of
//               wrapping, so o_tc stays asserted until cleared or reloaded.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_clr           - clear to zero (highest priority)
//               i_load          - load i_load_val
//               i_load_val      - value loaded by i_load
//               i_en            - count up by one
//               o_tc            - count equals TC_VAL
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_timer #(
    parameter int TC_VAL = 15,
    parameter int CNT_W  = (TC_VAL > 0) ? $clog2(TC_VAL + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] C_TC = CNT_W'(TC_VAL);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = (r_cnt == C_TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && !w_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = w_tc;

endmodule : mem_arb_timer
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between instruction fetch
//               and MEM-stage data access. Each access runs IDLE -> BUSY ->
//               RESP. Data wins ties, but after D_BURST_MAX consecutive data
//               grants with fetch waiting, fetch is granted. A BUSY phase
//               that sees no mem_ack_i for TIMEOUT_CYC cycles is completed
//               with ERR_DATA and raises the sticky err_o.
// Ports       : clk_i, rst_i                   - clock, sync active-high reset
//               if_req_i/if_addr_i             - fetch request (level)
//               if_ack_o/if_rdata_o            - fetch completion, read word
//               d_req_i/d_we_i/d_addr_i/d_wdata_i - data request (level)
//               d_ack_o/d_rdata_o              - data completion, read word
//               mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o - memory request
//               mem_ack_i/mem_rdata_i          - memory completion, read data
//               stall_o                        - any request still unanswered
//               err_o                          - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                D_BURST_MAX = 2,
    parameter int                TIMEOUT_CYC = 16,
    parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic              err_o
);

    localparam int BURST_W = (D_BURST_MAX > 0) ? $clog2(D_BURST_MAX + 1) : 1;
    localparam logic [BURST_W-1:0] C_BURST_MAX = BURST_W'(D_BURST_MAX);
    localparam int TMO_TC  = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam int TMO_W   = (TMO_TC > 0) ? $clog2(TMO_TC + 1) : 1;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_owner_t        r_owner;
    logic [BURST_W-1:0] r_burst;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_err;

    logic              w_grant_d;
    logic              w_grant_if;
    logic              w_grant;
    logic              w_done;
    logic              w_tmo_tc;
    logic              w_tmo_clr;
    logic              w_tmo_en;
    logic [DATA_W-1:0] w_rsp_data;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state, grant selection and completion detect
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_if  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Data wins unless fetch is waiting and the burst budget is spent.
                if (d_req_i && (!if_req_i || (r_burst != C_BURST_MAX))) begin
                    w_grant_d = 1'b1;
                end else if (if_req_i) begin
                    w_grant_if = 1'b1;
                end
                if (w_grant_d || w_grant_if) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                // A real ack takes precedence over a coincident timeout.
                if (mem_ack_i || w_tmo_tc) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_grant    = w_grant_d | w_grant_if;
    assign w_rsp_data = mem_ack_i ? mem_rdata_i : ERR_DATA;

    // ------------------------------------------------------------------
    // Request, response and bookkeeping registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner     <= OWN_IF;
            r_burst     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_grant) begin
                r_owner     <= w_grant_d ? OWN_D : OWN_IF;
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_grant_d & d_we_i;
                r_mem_addr  <= w_grant_d ? d_addr_i : if_addr_i;
                r_mem_wdata <= w_grant_d ? d_wdata_i : '0;
            end

            if (w_done) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                if (r_owner == OWN_IF) begin
                    r_if_rdata <= w_rsp_data;
                end else if (!r_mem_we) begin
                    r_d_rdata <= w_rsp_data;
                end
                if (!mem_ack_i) begin
                    r_err <= 1'b1;
                end
            end

            // Count data grants made while fetch is kept waiting.
            if (!if_req_i) begin
                r_burst <= '0;
            end else if (w_grant_d) begin
                if (r_burst != C_BURST_MAX) begin
                    r_burst <= r_burst + 1'b1;
                end
            end else if (w_grant_if) begin
                r_burst <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Timeout counter: restarts on each grant, runs only while BUSY
    // ------------------------------------------------------------------
    assign w_tmo_clr = (r_state == S_RESP);
    assign w_tmo_en  = (r_state == S_BUSY);

    mem_arb_timer #(
        .TC_VAL (TMO_TC),
        .CNT_W  (TMO_W)
    ) u_tmo_timer (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_clr      (w_tmo_clr),
        .i_load     (w_grant),
        .i_load_val ({TMO_W{1'b0}}),
        .i_en       (w_tmo_en),
        .o_tc       (w_tmo_tc)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign if_ack_o    = (r_state == S_RESP) && (r_owner == OWN_IF);
    assign d_ack_o     = (r_state == S_RESP) && (r_owner == OWN_D);
    assign if_rdata_o  = r_if_rdata;
    assign d_rdata_o   = r_d_rdata;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign err_o       = r_err;
    assign stall_o     = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter. A small
//               memory responder acknowledges after a programmable number of
//               BUSY cycles (or never) and logs which requester owns each
//               memory request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_ack_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [31:0] d_addr_i = '0;
    logic [31:0] d_wdata_i = '0;
    logic        d_ack_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'hBAD0BAD0;
    logic        stall_o;
    logic        err_o;

    int          n_checks = 0;
    int          n_fail   = 0;

    // responder controls
    int          ack_delay = 0;
    bit          ack_never = 1'b0;
    logic [31:0] resp_data = '0;
    int          busy_idx  = 0;
    bit          log_en    = 1'b0;
    bit          glog[$];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_ack_o    (if_ack_o),
        .if_rdata_o  (if_rdata_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_ack_o     (d_ack_o),
        .d_rdata_o   (d_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memory model: acks in BUSY cycle number ack_delay (0 = first BUSY cycle).
    always @(posedge clk) begin
        #1;
        if (mem_req_o) begin
            if (log_en && busy_idx == 0) glog.push_back(mem_addr_o == 32'h200);
            if (!ack_never && busy_idx == ack_delay) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = resp_data;
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = 32'hBAD0BAD0;
            end
            busy_idx++;
        end else begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hBAD0BAD0;
            busy_idx    = 0;
        end
    end

    // Issue one access (call just after a rising edge), wait for its ack,
    // then drop the request at the edge ending the ack cycle.
    task automatic run_access(input bit is_d, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int delay, input bit never,
                              input logic [31:0] resp, output int lat, output int nbusy,
                              output bit stall_pre, output bit stall_ack,
                              output bit stable, output bit got);
        logic [31:0] a0;
        logic        we0;
        ack_delay = delay;
        ack_never = never;
        resp_data = resp;
        if (is_d) begin
            d_req_i = 1'b1; d_we_i = we; d_addr_i = addr; d_wdata_i = wdata;
        end else begin
            if_req_i = 1'b1; if_addr_i = addr;
        end
        lat = -1; nbusy = 0; stall_pre = 1'b1; stall_ack = 1'b1; stable = 1'b1; got = 1'b0;
        a0 = '0; we0 = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (is_d ? d_ack_o : if_ack_o) begin
                got = 1'b1; lat = c; stall_ack = stall_o;
                break;
            end
            if (!stall_o) stall_pre = 1'b0;
            if (mem_req_o) begin
                if (nbusy == 0) begin
                    a0 = mem_addr_o; we0 = mem_we_o;
                end else if (mem_addr_o !== a0 || mem_we_o !== we0) begin
                    stable = 1'b0;
                end
                nbusy++;
            end
        end
        @(posedge clk); #1;
        if (is_d) d_req_i = 1'b0; else if_req_i = 1'b0;
        d_we_i = 1'b0;
    endtask

    int lat, nbusy;
    bit stall_pre, stall_ack, stable, got, drop_d, drop_if, done;

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_acks", {if_ack_o, d_ack_o}, 0);
        chk("rst_err", err_o, 0);
        chk("rst_if_rdata", if_rdata_o, 0);
        chk("rst_d_rdata", d_rdata_o, 0);
        chk("rst_stall", stall_o, 0);
        @(posedge clk); #1;

        // ---------------- fetch-only, immediate ack ----------------
        run_access(1'b0, 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'h8C020004,
                   lat, nbusy, stall_pre, stall_ack, stable, got);
        chk("f1_got", got, 1);
        chk("f1_lat", lat, 2);
        chk("f1_busy", nbusy, 1);
        chk("f1_rdata", if_rdata_o, 32'h8C020004);
        chk("f1_stall_pre", stall_pre, 1);
        chk("f1_stall_ack", stall_ack, 0);
        @(negedge clk);
        chk("f1_ack_gone", if_ack_o, 0);
        chk("f1_rdata_held", if_rdata_o, 32'h8C020004);
        @(posedge clk); #1;

        // ---------------- data read, ack delayed 3 ----------------
        run_access(1'b1, 1'b0, 32'h80, 32'h0, 3, 1'b0, 32'h12345678,
                   lat, nbusy, stall_pre, stall_ack, stable, got);
        chk("d3_got", got, 1);
        chk("d3_lat", lat, 5);
        chk("d3_busy", nbusy, 4);
        chk("d3_stable", stable, 1);
        chk("d3_rdata", d_rdata_o, 32'h12345678);
        chk("d3_stall_ack", stall_ack, 0);
        chk("d3_if_rdata", if_rdata_o, 32'h8C020004);

        // ---------------- simultaneous fetch + data write ----------------
        ack_delay = 0; ack_never = 1'b0; resp_data = 32'hCAFE0001;
        if_req_i = 1'b1; if_addr_i = 32'h20;
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h100; d_wdata_i = 32'h55;
        @(negedge clk);
        chk("sim_idle_stall", stall_o, 1);
        chk("sim_idle_req", mem_req_o, 0);
        @(negedge clk);
        chk("sim_d_req", mem_req_o, 1);
        chk("sim_d_we", mem_we_o, 1);
        chk("sim_d_addr", mem_addr_o, 32'h100);
        chk("sim_d_wdata", mem_wdata_o, 32'h55);
        @(negedge clk);
        chk("sim_d_ack", {if_ack_o, d_ack_o}, 2'b01);
        chk("sim_d_rdata_keep", d_rdata_o, 32'h12345678);
        chk("sim_stall_if", stall_o, 1);
        @(posedge clk); #1;
        d_req_i = 1'b0; d_we_i = 1'b0;
        @(negedge clk);
        chk("sim_gap", {mem_req_o, d_ack_o}, 0);
        @(negedge clk);
        chk("sim_if_req", mem_req_o, 1);
        chk("sim_if_addr", mem_addr_o, 32'h20);
        chk("sim_if_we", mem_we_o, 0);
        @(negedge clk);
        chk("sim_if_ack", {if_ack_o, d_ack_o}, 2'b10);
        chk("sim_if_rdata", if_rdata_o, 32'hCAFE0001);
        chk("sim_d_rdata_end", d_rdata_o, 32'h12345678);
        @(posedge clk); #1;
        if_req_i = 1'b0;
        @(posedge clk); #1;

        // ---------------- burst limit: expect D D IF D D IF ----------------
        glog.delete();
        log_en = 1'b1; ack_delay = 0; resp_data = 32'h0000BEEF;
        if_req_i = 1'b1; if_addr_i = 32'h40;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200;
        drop_d = 1'b0; drop_if = 1'b0; done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (d_ack_o && glog.size() >= 5) drop_d = 1'b1;
            if (if_ack_o && glog.size() >= 6) drop_if = 1'b1;
            @(posedge clk); #1;
            if (drop_d) d_req_i = 1'b0;
            if (drop_if) begin
                if_req_i = 1'b0;
                done = 1'b1;
                break;
            end
        end
        log_en = 1'b0;
        chk("burst_done", done, 1);
        chk("burst_count", glog.size(), 6);
        if (glog.size() >= 6) begin
            chk("burst_g0", glog[0], 1);
            chk("burst_g1", glog[1], 1);
            chk("burst_g2", glog[2], 0);
            chk("burst_g3", glog[3], 1);
            chk("burst_g4", glog[4], 1);
            chk("burst_g5", glog[5], 0);
        end
        chk("burst_err", err_o, 0);
        @(posedge clk); #1;

        // ---------------- ack on the timeout cycle counts as real ----------------
        run_access(1'b1, 1'b0, 32'h300, 32'h0, 15, 1'b0, 32'hA5A5A5A5,
                   lat, nbusy, stall_pre, stall_ack, stable, got);
        chk("edge_got", got, 1);
        chk("edge_lat", lat, 17);
        chk("edge_rdata", d_rdata_o, 32'hA5A5A5A5);
        chk("edge_err", err_o, 0);

        // ---------------- no ack at all: timeout ----------------
        run_access(1'b1, 1'b0, 32'h304, 32'h0, 0, 1'b1, 32'h0,
                   lat, nbusy, stall_pre, stall_ack, stable, got);
        chk("tmo_got", got, 1);
        chk("tmo_busy", nbusy, 16);
        chk("tmo_lat", lat, 17);
        chk("tmo_rdata", d_rdata_o, 32'hDEADBEEF);
        chk("tmo_err", err_o, 1);
        chk("tmo_stable", stable, 1);

        // good access afterwards: err stays set
        run_access(1'b0, 1'b0, 32'h44, 32'h0, 1, 1'b0, 32'h0BADF00D,
                   lat, nbusy, stall_pre, stall_ack, stable, got);
        chk("post_got", got, 1);
        chk("post_lat", lat, 3);
        chk("post_rdata", if_rdata_o, 32'h0BADF00D);
        chk("post_err", err_o, 1);

        // ---------------- reset in the 3rd BUSY cycle ----------------
        ack_never = 1'b1;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h400;
        @(negedge clk);
        @(negedge clk);
        chk("rmid_busy1", mem_req_o, 1);
        @(negedge clk);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(negedge clk);
        chk("rmid_busy3", mem_req_o, 1);
        @(posedge clk); #1;
        rst_i = 1'b0; ack_never = 1'b0; ack_delay = 0; resp_data = 32'h600DF00D;
        @(negedge clk);
        chk("rmid_req", mem_req_o, 0);
        chk("rmid_ack", d_ack_o, 0);
        chk("rmid_err", err_o, 0);
        chk("rmid_addr", mem_addr_o, 0);
        chk("rmid_d_rdata", d_rdata_o, 0);
        chk("rmid_stall", stall_o, 1);
        @(negedge clk);
        chk("rmid_regrant", mem_req_o, 1);
        chk("rmid_regrant_addr", mem_addr_o, 32'h400);
        @(negedge clk);
        chk("rmid_ack2", d_ack_o, 1);
        chk("rmid_rdata2", d_rdata_o, 32'h600DF00D);
        @(posedge clk); #1;
        d_req_i = 1'b0;
        @(negedge clk);
        chk("rmid_ack_gone", d_ack_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
